scaled_window_reader: RTL and testbench

SCALED_WINDOW_READER -- requirements
Module: scaled_window_reader

---
 rtl/scaled_window_reader.sv | 126 ++++++++++++
 tb/tb_scaled_window_reader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/scaled_window_reader.sv
// Maps VGA scan coordinates onto a centred, power-of-two scaled window of a
// source image and fetches its pixels through a fixed 3-cycle pipeline.
module scaled_window_reader #(
  parameter int          SRC_W    = 160,
  parameter int          SRC_H    = 120,
  parameter int          H_ACT    = 640,
  parameter int          V_ACT    = 480,
  parameter int          XW       = 10,
  parameter int          ADDR_W   = 15,
  parameter int          MAX_LOG2 = 2,
  parameter logic [7:0]  BORDER   = 8'h00
) (
  input  logic              clk_vga,
  input  logic              vga_reset,
  input  logic [XW-1:0]     next_x,
  input  logic [XW-1:0]     next_y,
  input  logic              cfg_req,
  input  logic              cfg_zoom_out,
  input  logic [1:0]        cfg_log2,
  output logic              cfg_ack,
  output logic [ADDR_W-1:0] src_rd_addr,
  input  logic [7:0]        src_q,
  output logic [7:0]        color_out,
  output logic              in_image,
  output logic              frame_start
);

  localparam int WW = XW + MAX_LOG2;

  function automatic logic [WW-1:0] span(input int src, input int act,
                                         input logic zoom, input logic [1:0] k);
    logic [WW-1:0] s;
    s = zoom ? (WW'(src) >> k) : (WW'(src) << k);
    if (s > WW'(act)) s = WW'(act);
    return s;
  endfunction

  function automatic logic [WW-1:0] center(input int act, input logic [WW-1:0] s);
    return (WW'(act) - s) >> 1;
  endfunction

  localparam logic [WW-1:0] W0 = span(SRC_W, H_ACT, 1'b0, 2'd0);
  localparam logic [WW-1:0] H0 = span(SRC_H, V_ACT, 1'b0, 2'd0);
  localparam logic [WW-1:0] X0 = center(H_ACT, W0);
  localparam logic [WW-1:0] Y0 = center(V_ACT, H0);

  logic [XW-1:0] prev_y;
  logic          pend_valid;
  logic          pend_zoom;
  logic [1:0]    pend_k;
  logic          act_zoom;
  logic [1:0]    act_k;
  logic [WW-1:0] win_w, win_h, x_off, y_off;
  logic [1:0]    log2_sat;
  logic          win_d1, win_d2;

  logic [WW-1:0]     x_ext, y_ext, dx, dy, col, row;
  logic              in_win;
  logic [ADDR_W-1:0] addr_n;

  assign frame_start = (prev_y != '0) && (next_y == '0);
  // The ack is the apply strobe: pending slot only retires on a frame boundary.
  assign cfg_ack     = frame_start && pend_valid;
  assign log2_sat    = (int'(cfg_log2) > MAX_LOG2) ? 2'(MAX_LOG2) : cfg_log2;

  always_ff @(posedge clk_vga or posedge vga_reset) begin
    if (vga_reset) begin
      prev_y     <= '0;
      pend_valid <= 1'b0;
      pend_zoom  <= 1'b0;
      pend_k     <= 2'd0;
      act_zoom   <= 1'b0;
      act_k      <= 2'd0;
      win_w      <= W0;
      win_h      <= H0;
      x_off      <= X0;
      y_off      <= Y0;
    end else begin
      prev_y <= next_y;
      if (cfg_ack) begin
        act_zoom   <= pend_zoom;
        act_k      <= pend_k;
        win_w      <= span(SRC_W, H_ACT, pend_zoom, pend_k);
        win_h      <= span(SRC_H, V_ACT, pend_zoom, pend_k);
        x_off      <= center(H_ACT, span(SRC_W, H_ACT, pend_zoom, pend_k));
        y_off      <= center(V_ACT, span(SRC_H, V_ACT, pend_zoom, pend_k));
        pend_valid <= 1'b0;
      end else if (cfg_req && !pend_valid) begin
        pend_valid <= 1'b1;
        pend_zoom  <= cfg_zoom_out;
        pend_k     <= log2_sat;
      end
    end
  end

  always_comb begin
    x_ext  = WW'(next_x);
    y_ext  = WW'(next_y);
    dx     = x_ext - x_off;
    dy     = y_ext - y_off;
    // x_off + win_w never exceeds the active area, so blanking falls outside.
    in_win = (x_ext >= x_off) && (x_ext < x_off + win_w) &&
             (y_ext >= y_off) && (y_ext < y_off + win_h);
    col    = act_zoom ? (dx << act_k) : (dx >> act_k);
    row    = act_zoom ? (dy << act_k) : (dy >> act_k);
    addr_n = ADDR_W'(row) * ADDR_W'(SRC_W) + ADDR_W'(col);
  end

  always_ff @(posedge clk_vga or posedge vga_reset) begin
    if (vga_reset) begin
      src_rd_addr <= '0;
      win_d1      <= 1'b0;
      win_d2      <= 1'b0;
      in_image    <= 1'b0;
      color_out   <= 8'h00;
    end else begin
      src_rd_addr <= in_win ? addr_n : '0;
      win_d1      <= in_win;
      // win_d2 lines up with src_q for the address issued one cycle earlier.
      win_d2      <= win_d1;
      in_image    <= win_d2;
      color_out   <= win_d2 ? src_q : BORDER;
    end
  end

endmodule

// File: tb/tb_scaled_window_reader.sv
// Directed bench for scaled_window_reader with a 1-cycle source memory whose
// data is the low byte of the read address.
module tb_scaled_window_reader;

  logic        clk_vga = 1'b0;
  logic        vga_reset;
  logic [9:0]  next_x, next_y;
  logic        cfg_req, cfg_zoom_out;
  logic [1:0]  cfg_log2;
  logic        cfg_ack;
  logic [14:0] src_rd_addr;
  logic [7:0]  src_q;
  logic [7:0]  color_out;
  logic        in_image;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  localparam logic [9:0] IDLE_X = 10'd1000;

  scaled_window_reader dut (
    .clk_vga      (clk_vga),
    .vga_reset    (vga_reset),
    .next_x       (next_x),
    .next_y       (next_y),
    .cfg_req      (cfg_req),
    .cfg_zoom_out (cfg_zoom_out),
    .cfg_log2     (cfg_log2),
    .cfg_ack      (cfg_ack),
    .src_rd_addr  (src_rd_addr),
    .src_q        (src_q),
    .color_out    (color_out),
    .in_image     (in_image),
    .frame_start  (frame_start)
  );

  always #5 clk_vga = ~clk_vga;

  always @(posedge clk_vga) src_q <= src_rd_addr[7:0];

  task automatic step();
    @(posedge clk_vga);
    #1;
  endtask

  // Present one coordinate for a single cycle, then park on a blanking column.
  task automatic drive_coord(input logic [9:0] x, input logic [9:0] y,
                             output logic [14:0] a, output logic ii, output logic [7:0] c);
    next_x = x;
    next_y = y;
    step();
    a = src_rd_addr;
    next_x = IDLE_X;
    step();
    step();
    ii = in_image;
    c  = color_out;
  endtask

  task automatic frame_edge(output logic fs, output logic ak);
    next_y = 10'd479;
    step();
    next_y = 10'd0;
    #1;
    fs = frame_start;
    ak = cfg_ack;
  endtask

  task automatic test_reset();
    vga_reset = 1'b1;
    next_x = 10'd0; next_y = 10'd0;
    cfg_req = 1'b0; cfg_zoom_out = 1'b0; cfg_log2 = 2'd0;
    step(); step();
    checks++; if (src_rd_addr !== 15'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", src_rd_addr); end
    checks++; if (color_out !== 8'h00) begin errors++; $display("FAIL reset_color got %h exp 00", color_out); end
    checks++; if (in_image !== 1'b0) begin errors++; $display("FAIL reset_in_image got %b exp 0", in_image); end
    checks++; if (cfg_ack !== 1'b0 || frame_start !== 1'b0) begin errors++; $display("FAIL reset_pulses got ack=%b fs=%b exp 0 0", cfg_ack, frame_start); end
    vga_reset = 1'b0;
    step();
  endtask

  task automatic test_default();
    logic [14:0] a; logic ii; logic [7:0] c;
    drive_coord(10'd240, 10'd180, a, ii, c);
    checks++; if (a !== 15'd0) begin errors++; $display("FAIL def_tl_addr got %0d exp 0", a); end
    checks++; if (ii !== 1'b1 || c !== 8'h00) begin errors++; $display("FAIL def_tl_pix got in=%b c=%h exp 1 00", ii, c); end
    drive_coord(10'd399, 10'd299, a, ii, c);
    checks++; if (a !== 15'd19199) begin errors++; $display("FAIL def_br_addr got %0d exp 19199", a); end
    checks++; if (ii !== 1'b1 || c !== 8'hFF) begin errors++; $display("FAIL def_br_pix got in=%b c=%h exp 1 ff", ii, c); end
    drive_coord(10'd239, 10'd180, a, ii, c);
    checks++; if (a !== 15'd0 || ii !== 1'b0 || c !== 8'h00) begin errors++; $display("FAIL def_left_out got a=%0d in=%b c=%h exp 0 0 00", a, ii, c); end
    drive_coord(10'd400, 10'd180, a, ii, c);
    checks++; if (ii !== 1'b0) begin errors++; $display("FAIL def_right_out got in=%b exp 0", ii); end
  endtask

  task automatic test_replicate();
    logic [14:0] a; logic ii; logic [7:0] c; logic fs, ak;
    next_y = 10'd50;
    cfg_req = 1'b1; cfg_zoom_out = 1'b0; cfg_log2 = 2'd2;
    step();
    cfg_req = 1'b0;
    frame_edge(fs, ak);
    checks++; if (fs !== 1'b1 || ak !== 1'b1) begin errors++; $display("FAIL rep_ack got fs=%b ack=%b exp 1 1", fs, ak); end
    step();
    checks++; if (cfg_ack !== 1'b0) begin errors++; $display("FAIL rep_ack_width got %b exp 0", cfg_ack); end
    drive_coord(10'd7, 10'd5, a, ii, c);
    checks++; if (a !== 15'd161) begin errors++; $display("FAIL rep_addr got %0d exp 161", a); end
    checks++; if (ii !== 1'b1 || c !== 8'hA1) begin errors++; $display("FAIL rep_pix got in=%b c=%h exp 1 a1", ii, c); end
    drive_coord(10'd639, 10'd479, a, ii, c);
    checks++; if (a !== 15'd19199 || ii !== 1'b1) begin errors++; $display("FAIL rep_corner got a=%0d in=%b exp 19199 1", a, ii); end
    drive_coord(10'd640, 10'd5, a, ii, c);
    checks++; if (ii !== 1'b0 || c !== 8'h00) begin errors++; $display("FAIL rep_blank got in=%b c=%h exp 0 00", ii, c); end
  endtask

  task automatic test_decimate();
    logic [14:0] a; logic ii; logic [7:0] c; logic fs, ak;
    next_y = 10'd50;
    cfg_req = 1'b1; cfg_zoom_out = 1'b1; cfg_log2 = 2'd1;
    step();
    cfg_req = 1'b0;
    // Hold a fresh request across the ack so it is re-captured next cycle.
    cfg_zoom_out = 1'b0; cfg_log2 = 2'd3;
    frame_edge(fs, ak);
    cfg_req = 1'b1;
    checks++; if (fs !== 1'b1 || ak !== 1'b1) begin errors++; $display("FAIL dec_ack got fs=%b ack=%b exp 1 1", fs, ak); end
    step();
    checks++; if (cfg_ack !== 1'b0) begin errors++; $display("FAIL dec_ack_width got %b exp 0", cfg_ack); end
    step();
    cfg_req = 1'b0;
    drive_coord(10'd281, 10'd211, a, ii, c);
    checks++; if (a !== 15'd322) begin errors++; $display("FAIL dec_addr got %0d exp 322", a); end
    checks++; if (ii !== 1'b1 || c !== 8'h42) begin errors++; $display("FAIL dec_pix got in=%b c=%h exp 1 42", ii, c); end
    drive_coord(10'd360, 10'd211, a, ii, c);
    checks++; if (a !== 15'd0 || ii !== 1'b0) begin errors++; $display("FAIL dec_right_out got a=%0d in=%b exp 0 0", a, ii); end
    drive_coord(10'd279, 10'd211, a, ii, c);
    checks++; if (ii !== 1'b0) begin errors++; $display("FAIL dec_left_out got in=%b exp 0", ii); end
  endtask

  task automatic test_saturate();
    logic [14:0] a; logic ii; logic [7:0] c; logic fs, ak;
    frame_edge(fs, ak);
    checks++; if (fs !== 1'b1 || ak !== 1'b1) begin errors++; $display("FAIL sat_recapture_ack got fs=%b ack=%b exp 1 1", fs, ak); end
    step();
    drive_coord(10'd7, 10'd5, a, ii, c);
    checks++; if (a !== 15'd161 || ii !== 1'b1) begin errors++; $display("FAIL sat_addr got a=%0d in=%b exp 161 1", a, ii); end
    drive_coord(10'd639, 10'd479, a, ii, c);
    checks++; if (a !== 15'd19199 || ii !== 1'b1) begin errors++; $display("FAIL sat_corner got a=%0d in=%b exp 19199 1", a, ii); end
  endtask

  task automatic test_mid_frame();
    logic [14:0] a; logic ii; logic [7:0] c; logic fs, ak;
    next_x = 10'd300; next_y = 10'd100;
    cfg_req = 1'b1; cfg_zoom_out = 1'b1; cfg_log2 = 2'd1;
    step();
    cfg_zoom_out = 1'b0; cfg_log2 = 2'd0;
    step();
    cfg_req = 1'b0;
    checks++; if (cfg_ack !== 1'b0) begin errors++; $display("FAIL mid_no_early_ack got %b exp 0", cfg_ack); end
    drive_coord(10'd8, 10'd200, a, ii, c);
    checks++; if (a !== 15'd8002 || ii !== 1'b1 || c !== 8'h42) begin errors++; $display("FAIL mid_old_map got a=%0d in=%b c=%h exp 8002 1 42", a, ii, c); end
    frame_edge(fs, ak);
    checks++; if (fs !== 1'b1 || ak !== 1'b1) begin errors++; $display("FAIL mid_ack got fs=%b ack=%b exp 1 1", fs, ak); end
    step();
    checks++; if (cfg_ack !== 1'b0 || frame_start !== 1'b0) begin errors++; $display("FAIL mid_pulse_width got ack=%b fs=%b exp 0 0", cfg_ack, frame_start); end
    drive_coord(10'd8, 10'd0, a, ii, c);
    checks++; if (a !== 15'd0 || ii !== 1'b0) begin errors++; $display("FAIL mid_row0_new got a=%0d in=%b exp 0 0", a, ii); end
    drive_coord(10'd281, 10'd211, a, ii, c);
    checks++; if (a !== 15'd322 || c !== 8'h42) begin errors++; $display("FAIL mid_second_ignored got a=%0d c=%h exp 322 42", a, c); end
    frame_edge(fs, ak);
    checks++; if (fs !== 1'b1 || ak !== 1'b0) begin errors++; $display("FAIL mid_no_extra_ack got fs=%b ack=%b exp 1 0", fs, ak); end
    step();
  endtask

  task automatic test_reset_mid_frame();
    logic [14:0] a; logic ii; logic [7:0] c; logic fs, ak;
    next_x = 10'd281; next_y = 10'd211;
    step(); step(); step();
    checks++; if (in_image !== 1'b1 || color_out !== 8'h42) begin errors++; $display("FAIL rst_pre got in=%b c=%h exp 1 42", in_image, color_out); end
    cfg_req = 1'b1; cfg_zoom_out = 1'b0; cfg_log2 = 2'd2;
    step();
    cfg_req = 1'b0;
    #1;
    vga_reset = 1'b1;
    next_y = 10'd0;
    #1;
    checks++; if (src_rd_addr !== 15'd0 || color_out !== 8'h00 || in_image !== 1'b0) begin errors++; $display("FAIL rst_async_data got a=%0d c=%h in=%b exp 0 00 0", src_rd_addr, color_out, in_image); end
    checks++; if (cfg_ack !== 1'b0 || frame_start !== 1'b0) begin errors++; $display("FAIL rst_async_pulses got ack=%b fs=%b exp 0 0", cfg_ack, frame_start); end
    step(); step();
    vga_reset = 1'b0;
    step();
    frame_edge(fs, ak);
    checks++; if (fs !== 1'b1 || ak !== 1'b0) begin errors++; $display("FAIL rst_pending_dropped got fs=%b ack=%b exp 1 0", fs, ak); end
    step();
    drive_coord(10'd240, 10'd180, a, ii, c);
    checks++; if (a !== 15'd0 || ii !== 1'b1) begin errors++; $display("FAIL rst_default_tl got a=%0d in=%b exp 0 1", a, ii); end
    drive_coord(10'd399, 10'd299, a, ii, c);
    checks++; if (a !== 15'd19199 || c !== 8'hFF) begin errors++; $display("FAIL rst_default_br got a=%0d c=%h exp 19199 ff", a, c); end
  endtask

  initial begin
    test_reset();
    test_default();
    test_replicate();
    test_decimate();
    test_saturate();
    test_mid_frame();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
